// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = WORD_W / 8;
  localparam int CNT_W  = 4;

  localparam logic ERR_OK     = 1'b0;
  localparam logic ERR_ACCESS = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Misaligned or beyond the last implemented word.
  function automatic logic access_err(input logic [31:0] addr, input logic [31:0] depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: one byte-enabled synchronous write port, one registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed access latency.
// The memory access happens on the edge that enters RESP; response is held until rsp_ready.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int             AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0]    DEPTH_W  = 32'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;

  logic              w_enter_resp;
  logic              w_op_we;
  logic [31:0]       w_op_addr;
  logic [WORD_W-1:0] w_op_wdata;
  logic [STRB_W-1:0] w_op_wstrb;
  logic              w_op_err;
  logic              w_rsp_err;
  logic [WORD_W-1:0] w_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (req_valid && req_ready) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_wstrb <= req_wstrb;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    req_ready    = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 0) begin
            w_state_nxt  = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt  = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // With zero latency the access coincides with acceptance, so the live request is used.
  assign w_op_we    = (LATENCY == 0) ? req_we    : r_we;
  assign w_op_addr  = (LATENCY == 0) ? req_addr  : r_addr;
  assign w_op_wdata = (LATENCY == 0) ? req_wdata : r_wdata;
  assign w_op_wstrb = (LATENCY == 0) ? req_wstrb : r_wstrb;
  assign w_op_err   = access_err(w_op_addr, DEPTH_W);

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_enter_resp && w_op_we && !w_op_err),
    .i_wstrb (w_op_wstrb),
    .i_waddr (w_op_addr[AW+1:2]),
    .i_wdata (w_op_wdata),
    .i_re    (w_enter_resp && !w_op_we && !w_op_err),
    .i_raddr (w_op_addr[AW+1:2]),
    .o_rdata (w_rdata)
  );

  assign w_rsp_err = access_err(r_addr, DEPTH_W);
  assign rsp_valid = (r_state == RESP);
  assign rsp_err   = (rsp_valid && w_rsp_err) ? ERR_ACCESS : ERR_OK;
  assign rsp_rdata = (rsp_valid && !r_we && !w_rsp_err) ? w_rdata : '0;

endmodule
